// File: rtl/dmem_wait_ctrl_if.sv
// dmem_wait_ctrl_if: CPU-to-data-memory handshake bundle (master = CPU side, slave = memory controller)
interface dmem_wait_ctrl_if;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] readdata;
  logic        stall;
  logic        err;
  modport master (output memread, memwrite, addr, wdata, input readdata, stall, err);
  modport slave  (input memread, memwrite, addr, wdata, output readdata, stall, err);
endinterface

// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl: word-addressed RAM with LAT wait states, stalling the CPU until each access completes
// Ports: clk (rising edge), reset (async, active-high),
//   bus (slave): memread/memwrite/addr/wdata in; readdata (registered), stall (comb), err out.
// Optional: define DMEM_ALIGN_CHECK_EN to reject misaligned requests with a one-cycle err pulse.
module dmem_wait_ctrl #(
  parameter int DEPTH = 64,
  parameter int LAT = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic reset,
  dmem_wait_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [31:0]   mem [DEPTH];
  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          wr_q, wr_d;
  logic          req, mis, start, commit;
  logic          unused_addr;
  // upper bits wrap the address space; low bits only matter to the alignment check
  assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};
  assign req = bus.memread | bus.memwrite;
`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q, err_d;
  assign mis = bus.addr[1:0] != 2'b00;
  // suppressed while err_q is high so a held bad request pulses every second cycle
  assign err_d = state_q == S_IDLE && req && mis && !err_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) err_q <= 1'b0;
    else err_q <= err_d;
  assign bus.err = err_q;
`else
  assign mis = 1'b0;
  assign bus.err = 1'b0;
`endif
  assign start  = state_q == S_IDLE && req && !mis;
  // exit test precedes the decrement, so the counter never wraps
  assign commit = state_q == S_BUSY && cnt_q == 4'd0;
  assign bus.stall = start || state_q == S_BUSY;
  assign bus.readdata = rdata_q;
  always_comb begin
    state_d = start ? S_BUSY : commit ? S_DONE : state_q == S_DONE ? S_IDLE : state_q;
    cnt_d   = start ? 4'(LAT - 1) : (state_q == S_BUSY && !commit) ? cnt_q - 4'd1 : cnt_q;
    idx_d   = start ? bus.addr[AW+1:2] : idx_q;
    wdata_d = start ? bus.wdata : wdata_q;
    wr_d    = start ? bus.memwrite : wr_q;
    rdata_d = (commit && !wr_q) ? mem[idx_q] : rdata_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      wr_q    <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  // RAM is never reset; reset forces IDLE asynchronously, which cancels any pending commit
  always_ff @(posedge clk)
    if (commit && wr_q) mem[idx_q] <= wdata_q;
endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// tb_dmem_wait_ctrl: randomized and directed bench against a transaction-timed reference model
module tb_dmem_wait_ctrl;
  localparam int DEPTH = 64;
  localparam int LAT = 2;
  localparam int AW = $clog2(DEPTH);
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  dmem_wait_ctrl_if bus ();
  dmem_wait_ctrl #(.DEPTH(DEPTH), .LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction
  // Model: an accepted request at cycle s stalls cycles s..s+LAT, commits at the end of
  // cycle s+LAT, and cycle s+LAT+1 is the stall-free completion cycle.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rd = 32'h0, m_wd = 32'h0;
  int m_idx = 0, m_s = 0, cyc = 0;
  bit m_active = 0, m_wr = 0, m_err = 0;
  always @(negedge clk) begin
    bit req, ok, free, inacc, done, nerr;
    req = bus.memread | bus.memwrite;
`ifdef DMEM_ALIGN_CHECK_EN
    ok = bus.addr[1:0] == 2'b00;
`else
    ok = 1'b1;
`endif
    if (reset) begin
      m_active = 0;
      m_rd = 32'h0;
      m_err = 0;
    end
    free  = !m_active;
    inacc = m_active && cyc <= m_s + LAT;
    done  = m_active && cyc == m_s + LAT + 1;
    chk("model_stall", {31'b0, bus.stall}, {31'b0, inacc || (free && req && ok)});
    chk("model_readdata", bus.readdata, m_rd);
    chk("model_err", {31'b0, bus.err}, {31'b0, m_err});
    if (!reset) begin
      if (inacc && cyc == m_s + LAT) begin
        if (m_wr) m_mem[m_idx] = m_wd;
        else m_rd = m_mem[m_idx];
      end
      nerr = free && req && !ok && !m_err;
      if (done) m_active = 0;
      else if (free && req && ok) begin
        m_active = 1;
        m_s = cyc;
        m_idx = int'(bus.addr[AW+1:2]);
        m_wd = bus.wdata;
        m_wr = bus.memwrite;
      end
      m_err = nerr;
    end
    cyc++;
  end
  // Drive one CPU cycle's request; for a memory op, hold it until stall drops and return stall count.
  task automatic acc(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, output int n);
    n = 0;
    @(posedge clk);
    #1;
    bus.memread = r;
    bus.memwrite = w;
    bus.addr = a;
    bus.wdata = d;
    if (r | w) begin
      @(negedge clk);
      while (bus.stall && n < 40) begin
        n++;
        @(negedge clk);
      end
      if (n >= 40) begin
        n_bad++;
        $display("FAIL stall_timeout: stall still high after %0d cycles", n);
      end
    end
  endtask
  initial begin
    int n;
    time t1;
    logic [31:0] a;
    bus.memread = 0;
    bus.memwrite = 0;
    bus.addr = 0;
    bus.wdata = 0;
    @(negedge clk);
    chk("reset_stall", {31'b0, bus.stall}, 32'h0);
    chk("reset_readdata", bus.readdata, 32'h0);
    chk("reset_err", {31'b0, bus.err}, 32'h0);
    @(posedge clk);
    #1 reset = 0;
    for (int i = 0; i < DEPTH; i++) acc(0, 1, 32'(i * 4), 32'h0, n);
    acc(0, 1, 32'h20, 32'hCAFEF00D, n);
    chk("store_stall_cycles", 32'(n), 32'd3);
    acc(1, 0, 32'h20, 32'h0, n);
    chk("load_stall_cycles", 32'(n), 32'd3);
    chk("load_cafef00d", bus.readdata, 32'hCAFEF00D);
    acc(0, 1, 32'h100, 32'h1, n);
    acc(1, 0, 32'h0, 32'h0, n);
    chk("addr_wrap", bus.readdata, 32'h1);
    acc(0, 1, 32'h0C, 32'hAA, n);
    acc(1, 0, 32'h0C, 32'h0, n);
    chk("preload_aa", bus.readdata, 32'hAA);
    acc(1, 1, 32'h08, 32'h55, n);
    chk("rw_keeps_readdata", bus.readdata, 32'hAA);
    acc(1, 0, 32'h08, 32'h0, n);
    chk("rw_wrote_55", bus.readdata, 32'h55);
    acc(0, 0, 32'h0, 32'h0, n);
    @(negedge clk);
    chk("nonmem_no_stall", {31'b0, bus.stall}, 32'h0);
    acc(1, 0, 32'h20, 32'h0, n);
    t1 = $time;
    chk("b2b_done1_stall", {31'b0, bus.stall}, 32'h0);
    acc(1, 0, 32'h08, 32'h0, n);
    chk("b2b_spacing", 32'($time - t1), 32'd40);
    chk("b2b_done2_stall", {31'b0, bus.stall}, 32'h0);
    @(posedge clk);
    #1;
    bus.memread = 0;
    bus.memwrite = 1;
    bus.addr = 32'h10;
    bus.wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1;
    bus.memwrite = 0;
    @(negedge clk);
    chk("midreset_stall", {31'b0, bus.stall}, 32'h0);
    chk("midreset_readdata", bus.readdata, 32'h0);
    @(posedge clk);
    #1 reset = 0;
    acc(1, 0, 32'h10, 32'h0, n);
    chk("midreset_no_commit", bus.readdata, 32'h0);
    acc(0, 1, 32'h10, 32'h12345678, n);
    acc(1, 0, 32'h0C, 32'h0, n);
    acc(1, 0, 32'h13, 32'h0, n);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("misalign_no_stall", 32'(n), 32'd0);
    acc(0, 0, 32'h0, 32'h0, n);
    @(negedge clk);
    chk("misalign_err", {31'b0, bus.err}, 32'h1);
    chk("misalign_readdata", bus.readdata, 32'hAA);
`else
    chk("misalign_stall_cycles", 32'(n), 32'd3);
    chk("misalign_reads_word4", bus.readdata, 32'h12345678);
`endif
    for (int i = 0; i < 300; i++) begin
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      case ($urandom_range(0, 3))
        0: acc(0, 0, a, $urandom, n);
        1: acc(1, 0, a, $urandom, n);
        2: acc(0, 1, a, $urandom, n);
        default: acc(1, 1, a, $urandom, n);
      endcase
    end
    @(posedge clk);
    #1;
    bus.memread = 0;
    bus.memwrite = 0;
    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
